// File: rtl/fp_spi_cmd_sequencer.sv
// Front-panel SPI command sequencer: frames bytes, decodes commands, drives LED/PWM registers and MISO.
// Optional LED readback command (8'h02) is enabled by defining FP_SPI_LED_READBACK_EN.
module fp_spi_cmd_sequencer #(
    parameter logic [7:0] WRITE_LED_PORT = 8'h01,
    parameter logic [7:0] WRITE_PWM_PORT = 8'h04,
    parameter logic [7:0] READ_CHIP_ID   = 8'h06,
    parameter logic [7:0] READ_STATUS    = 8'h07,
    parameter logic [7:0] CHIP_ID        = 8'h71,
    parameter int         NUM_PWM        = 2
) (
    input  logic                 SCLK,
    input  logic                 BITCNT_RST,
    input  logic                 SS,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [3:0]           LEDPORT,
    output logic [8*NUM_PWM-1:0] PWMPORT,
    output logic                 BYTE_STB,
    output logic                 CMD_ERR
);

    typedef enum logic [1:0] {S_CMD, S_DATA, S_ERR} state_t;

    localparam logic [2:0] PTR_LAST = 3'(NUM_PWM - 1);
`ifdef FP_SPI_LED_READBACK_EN
    localparam logic [7:0] READ_LED_PORT = 8'h02;
`endif

    state_t               r_state;
    logic [2:0]           r_bit_cnt;
    logic [6:0]           r_rx_shift;
    logic [7:0]           r_cmd;
    logic [7:0]           r_tx_byte;
    logic [2:0]           r_pwm_ptr;
    logic [3:0]           r_err_cnt;
    logic                 r_led_first;
    logic                 r_miso;
    logic [3:0]           r_led;
    logic [8*NUM_PWM-1:0] r_pwm;
    logic                 r_byte_stb;
    logic                 r_cmd_err;

    logic [7:0]           w_byte;
    logic                 w_done;
    logic                 w_cmd_valid;
    logic [7:0]           w_resp;

    // The byte completing this edge includes the bit currently on MOSI.
    assign w_byte = {MOSI, r_rx_shift};
    assign w_done = (r_bit_cnt == 3'd7);

    always_comb begin
        w_cmd_valid = 1'b0;
        w_resp      = 8'h00;
        if (w_byte == WRITE_LED_PORT || w_byte == WRITE_PWM_PORT) begin
            w_cmd_valid = 1'b1;
        end else if (w_byte == READ_CHIP_ID) begin
            w_cmd_valid = 1'b1;
            w_resp      = CHIP_ID;
        end else if (w_byte == READ_STATUS) begin
            w_cmd_valid = 1'b1;
            w_resp      = {r_err_cnt, 1'b0, r_pwm_ptr};
`ifdef FP_SPI_LED_READBACK_EN
        end else if (w_byte == READ_LED_PORT) begin
            w_cmd_valid = 1'b1;
            w_resp      = {4'b0000, r_led};
`endif
        end
    end

    always_ff @(posedge SCLK or posedge BITCNT_RST) begin
        if (BITCNT_RST) begin
            r_state     <= S_CMD;
            r_bit_cnt   <= 3'd0;
            r_rx_shift  <= 7'd0;
            r_cmd       <= 8'h00;
            r_tx_byte   <= 8'h00;
            r_pwm_ptr   <= 3'd0;
            r_err_cnt   <= 4'd0;
            r_led_first <= 1'b0;
            r_miso      <= 1'b0;
            r_led       <= 4'd0;
            r_pwm       <= '0;
            r_byte_stb  <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else if (SS) begin
            r_state    <= S_CMD;
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 7'd0;
            r_pwm_ptr  <= 3'd0;
            r_miso     <= 1'b0;
            r_byte_stb <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_rx_shift <= w_byte[7:1];
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            r_byte_stb <= w_done;
            case (r_state)
                S_CMD: begin
                    if (w_done) begin
                        if (w_cmd_valid) begin
                            r_state     <= S_DATA;
                            r_cmd       <= w_byte;
                            r_tx_byte   <= w_resp;
                            r_miso      <= w_resp[0];
                            r_led_first <= 1'b1;
                        end else begin
                            r_state   <= S_ERR;
                            r_cmd_err <= 1'b1;
                            r_miso    <= 1'b0;
                            if (r_err_cnt != 4'hF) begin
                                r_err_cnt <= r_err_cnt + 4'd1;
                            end
                        end
                    end
                end
                S_DATA: begin
                    // Presents the next response bit; wraps to bit 0 so reads repeat per byte.
                    r_miso <= r_tx_byte[r_bit_cnt + 3'd1];
                    if (w_done) begin
                        if (r_cmd == WRITE_LED_PORT) begin
                            if (r_led_first) begin
                                r_led <= w_byte[3:0];
                            end
                            r_led_first <= 1'b0;
                        end
                        if (r_cmd == WRITE_PWM_PORT) begin
                            for (int n = 0; n < NUM_PWM; n++) begin
                                if (r_pwm_ptr == 3'(n)) begin
                                    r_pwm[8*n +: 8] <= w_byte;
                                end
                            end
                            r_pwm_ptr <= (r_pwm_ptr == PTR_LAST) ? 3'd0 : r_pwm_ptr + 3'd1;
                        end
                    end
                end
                S_ERR: begin
                    r_miso <= 1'b0;
                end
                default: begin
                    r_state <= S_CMD;
                end
            endcase
        end
    end

    assign MISO     = r_miso;
    assign LEDPORT  = r_led;
    assign PWMPORT  = r_pwm;
    assign BYTE_STB = r_byte_stb;
    assign CMD_ERR  = r_cmd_err;

endmodule

// File: tb/tb_fp_spi_cmd_sequencer.sv
// Table-driven bench for fp_spi_cmd_sequencer; expectations follow FP_SPI_LED_READBACK_EN when defined.
module tb_fp_spi_cmd_sequencer;

    logic        SCLK = 1'b0;
    logic        BITCNT_RST;
    logic        SS;
    logic        MOSI;
    logic        MISO;
    logic [3:0]  LEDPORT;
    logic [15:0] PWMPORT;
    logic        BYTE_STB;
    logic        CMD_ERR;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [7:0]  cmd;
        int          nData;
        logic [23:0] data;
        logic        expErr;
        logic [7:0]  expResp;
        logic [3:0]  expLed;
        logic [15:0] expPwm;
    } vec_t;

    vec_t vecs[10];

    fp_spi_cmd_sequencer #(.NUM_PWM(2)) dut (
        .SCLK       (SCLK),
        .BITCNT_RST (BITCNT_RST),
        .SS         (SS),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .LEDPORT    (LEDPORT),
        .PWMPORT    (PWMPORT),
        .BYTE_STB   (BYTE_STB),
        .CMD_ERR    (CMD_ERR)
    );

    always #5 SCLK = ~SCLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Master drives MOSI and samples MISO on negedge; returns 1 time unit after the last posedge.
    task automatic sendBits(input logic [7:0] b, input int n, output logic [7:0] m);
        m = 8'h00;
        for (int i = 0; i < n; i++) begin
            @(negedge SCLK);
            m[i] = MISO;
            MOSI = b[i];
            SS   = 1'b0;
            @(posedge SCLK);
        end
        #1;
    endtask

    task automatic endFrame();
        @(negedge SCLK);
        SS   = 1'b1;
        MOSI = 1'b0;
        @(posedge SCLK);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        logic [7:0]  m;
        logic [23:0] d;
        d = v.data;
        sendBits(v.cmd, 8, m);
        checkOutput($sformatf("v%0d_cmdErr", idx), 32'(CMD_ERR), 32'(v.expErr));
        checkOutput($sformatf("v%0d_stbCmd", idx), 32'(BYTE_STB), 32'd1);
        for (int k = 0; k < v.nData; k++) begin
            sendBits(d[8*k +: 8], 8, m);
            checkOutput($sformatf("v%0d_miso%0d", idx, k), 32'(m), 32'(v.expResp));
        end
        endFrame();
        checkOutput($sformatf("v%0d_led", idx), 32'(LEDPORT), 32'(v.expLed));
        checkOutput($sformatf("v%0d_pwm", idx), 32'(PWMPORT), 32'(v.expPwm));
        checkOutput($sformatf("v%0d_errClr", idx), 32'(CMD_ERR), 32'd0);
        checkOutput($sformatf("v%0d_stbClr", idx), 32'(BYTE_STB), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] m;
        vec_t       v;

        vecs[0] = '{8'h01, 1, 24'h0000A5, 1'b0, 8'h00, 4'h5, 16'h0000};
        vecs[1] = '{8'h04, 3, 24'h302010, 1'b0, 8'h00, 4'h5, 16'h2030};
        vecs[2] = '{8'h06, 2, 24'h00FF00, 1'b0, 8'h71, 4'h5, 16'h2030};
        vecs[3] = '{8'h01, 2, 24'h000A03, 1'b0, 8'h00, 4'h3, 16'h2030};
        vecs[4] = '{8'h07, 1, 24'h000000, 1'b0, 8'h00, 4'h3, 16'h2030};
        vecs[5] = '{8'h55, 1, 24'h000012, 1'b1, 8'h00, 4'h3, 16'h2030};
        vecs[6] = '{8'h07, 1, 24'h000000, 1'b0, 8'h10, 4'h3, 16'h2030};
        vecs[7] = '{8'h04, 1, 24'h000044, 1'b0, 8'h00, 4'h3, 16'h2044};
`ifdef FP_SPI_LED_READBACK_EN
        vecs[8] = '{8'h02, 1, 24'h000000, 1'b0, 8'h03, 4'h3, 16'h2044};
        vecs[9] = '{8'h07, 1, 24'h000000, 1'b0, 8'h10, 4'h3, 16'h2044};
`else
        vecs[8] = '{8'h02, 1, 24'h000000, 1'b1, 8'h00, 4'h3, 16'h2044};
        vecs[9] = '{8'h07, 1, 24'h000000, 1'b0, 8'h20, 4'h3, 16'h2044};
`endif

        BITCNT_RST = 1'b1;
        SS         = 1'b1;
        MOSI       = 1'b0;
        #12;
        checkOutput("rst_led",  32'(LEDPORT),  32'd0);
        checkOutput("rst_pwm",  32'(PWMPORT),  32'd0);
        checkOutput("rst_miso", 32'(MISO),     32'd0);
        checkOutput("rst_stb",  32'(BYTE_STB), 32'd0);
        checkOutput("rst_err",  32'(CMD_ERR),  32'd0);
        BITCNT_RST = 1'b0;
        @(posedge SCLK);
        #1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Seventeen bad commands saturate the error counter at 15.
        for (int f = 0; f < 17; f++) begin
            sendBits(8'h55, 8, m);
            checkOutput($sformatf("bad%0d_cmdErr", f), 32'(CMD_ERR), 32'd1);
            endFrame();
        end
        v = '{8'h07, 1, 24'h000000, 1'b0, 8'hF0, 4'h3, 16'h2044};
        applyStimulus(20, v);

        // Abort mid data byte leaves PWM untouched and rewinds the channel pointer.
        sendBits(8'h04, 8, m);
        checkOutput("abort_stbHigh", 32'(BYTE_STB), 32'd1);
        sendBits(8'h7A, 4, m);
        checkOutput("abort_stbLow", 32'(BYTE_STB), 32'd0);
        endFrame();
        checkOutput("abort_pwm", 32'(PWMPORT), 32'h2044);
        v = '{8'h04, 1, 24'h000099, 1'b0, 8'h00, 4'h3, 16'h2099};
        applyStimulus(21, v);

        // Asynchronous reset in the middle of a chip-ID read data byte.
        sendBits(8'h06, 8, m);
        sendBits(8'h00, 4, m);
        checkOutput("preRst_miso", 32'(MISO), 32'd1);
        #2;
        BITCNT_RST = 1'b1;
        #1;
        checkOutput("midRst_led",  32'(LEDPORT),  32'd0);
        checkOutput("midRst_pwm",  32'(PWMPORT),  32'd0);
        checkOutput("midRst_miso", 32'(MISO),     32'd0);
        checkOutput("midRst_stb",  32'(BYTE_STB), 32'd0);
        checkOutput("midRst_err",  32'(CMD_ERR),  32'd0);
        BITCNT_RST = 1'b0;
        sendBits(8'h06, 8, m);
        checkOutput("postRst_cmdErr", 32'(CMD_ERR), 32'd0);
        sendBits(8'h00, 8, m);
        checkOutput("postRst_chipId", 32'(m), 32'h71);
        endFrame();
        v = '{8'h07, 1, 24'h000000, 1'b0, 8'h00, 4'h0, 16'h0000};
        applyStimulus(22, v);
        v = '{8'h01, 1, 24'h00000C, 1'b0, 8'h00, 4'hC, 16'h0000};
        applyStimulus(23, v);
`ifdef FP_SPI_LED_READBACK_EN
        v = '{8'h02, 1, 24'h000000, 1'b0, 8'h0C, 4'hC, 16'h0000};
`else
        v = '{8'h02, 1, 24'h000000, 1'b1, 8'h00, 4'hC, 16'h0000};
`endif
        applyStimulus(24, v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
